// File: rtl/l2_wbuf_pkg.sv
// l2_wbuf_pkg: shared types and constants for the L2 write-back buffer.
//   wbuf_state_t : controller states
//   wbuf_entry_t : one buffered dirty line {valid, tag, data}
//   line_addr()  : rebuilds a line-aligned byte address from a tag
package l2_wbuf_pkg;

    localparam int unsigned LINE_BITS   = 256;
    localparam int unsigned OFFSET_BITS = 5;
    localparam int unsigned TAG_BITS    = 32 - OFFSET_BITS;

    typedef enum logic [2:0] {
        StIdle,
        StWrAck,
        StRdAck,
        StReadMem,
        StDrain
    } wbuf_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_BITS-1:0]  tag;
        logic [LINE_BITS-1:0] data;
    } wbuf_entry_t;

    function automatic logic [31:0] line_addr(input logic [TAG_BITS-1:0] tag);
        return {tag, {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/l2_wbuf_store.sv
// l2_wbuf_store: circular FIFO of dirty lines with a parallel tag lookup.
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   push_i/_tag_i/_data_i   append a line at the tail
//   pop_i                   retire the head entry
//   ovr_i/_idx_i/_data_i    overwrite the data of an existing entry in place
//   lookup_tag_i            tag compared against all valid entries
//   hit_o/hit_idx_o/hit_data_o  lookup result
//   head_tag_o/head_data_o  oldest entry (next to drain)
//   count_o                 number of valid entries, 0..Depth
module l2_wbuf_store
    import l2_wbuf_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned IdxW = $clog2(Depth),
    localparam int unsigned CntW = IdxW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [TAG_BITS-1:0]  push_tag_i,
    input  logic [LINE_BITS-1:0] push_data_i,
    input  logic                 pop_i,
    input  logic                 ovr_i,
    input  logic [IdxW-1:0]      ovr_idx_i,
    input  logic [LINE_BITS-1:0] ovr_data_i,
    input  logic [TAG_BITS-1:0]  lookup_tag_i,
    output logic                 hit_o,
    output logic [IdxW-1:0]      hit_idx_o,
    output logic [LINE_BITS-1:0] hit_data_o,
    output logic [TAG_BITS-1:0]  head_tag_o,
    output logic [LINE_BITS-1:0] head_data_o,
    output logic [CntW-1:0]      count_o
);

    wbuf_entry_t     entries_q [Depth];
    logic [IdxW-1:0] head_q, tail_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    // Guards keep count inside 0..Depth even if a caller misbehaves.
    assign do_push = push_i && (count_q != CntW'(Depth));
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else begin
            if (do_push) begin
                entries_q[tail_q] <= '{valid: 1'b1, tag: push_tag_i, data: push_data_i};
                tail_q            <= tail_q + IdxW'(1);
            end
            if (ovr_i) begin
                entries_q[ovr_idx_i].data <= ovr_data_i;
            end
            if (do_pop) begin
                entries_q[head_q].valid <= 1'b0;
                head_q                  <= head_q + IdxW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: ;
            endcase
        end
    end

    // At most one valid entry per tag, so the last match is the only match.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int i = 0; i < Depth; i++) begin
            if (entries_q[i].valid && (entries_q[i].tag == lookup_tag_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IdxW'(i);
            end
        end
    end

    assign hit_data_o  = entries_q[hit_idx_o].data;
    assign head_tag_o  = entries_q[head_q].tag;
    assign head_data_o = entries_q[head_q].data;
    assign count_o     = count_q;

endmodule

// File: rtl/l2_write_buffer.sv
// l2_write_buffer: write-back buffer between the L2 memory port and main memory.
// Absorbs evictions with a 1-cycle ack, serves read hits from buffered lines,
// and drains lines to memory whenever the L2 side is idle.
// Ports:
//   clk_i, rst_ni                        clock, synchronous active-low reset
//   mem_read_i/mem_write_i/mem_address_i/mem_wdata_i   L2 request (held until mem_resp_o)
//   mem_resp_o/mem_rdata_o               completion pulse and read data to L2
//   pmem_read_o/pmem_write_o/pmem_address_o/pmem_wdata_o  memory request
//   pmem_resp_i/pmem_rdata_i             memory completion and read data
// Build option: L2_WBUF_COALESCE_EN -- a write hitting a buffered line overwrites it in
// place instead of waiting for that line to drain.
module l2_write_buffer
    import l2_wbuf_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [31:0]          mem_address_i,
    input  logic [LINE_BITS-1:0] mem_wdata_i,
    output logic                 mem_resp_o,
    output logic [LINE_BITS-1:0] mem_rdata_o,
    output logic                 pmem_read_o,
    output logic                 pmem_write_o,
    output logic [31:0]          pmem_address_o,
    output logic [LINE_BITS-1:0] pmem_wdata_o,
    input  logic                 pmem_resp_i,
    input  logic [LINE_BITS-1:0] pmem_rdata_i
);

    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned CntW = IdxW + 1;

    wbuf_state_t          state_q, state_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;
    logic                 push, pop, ovr, hit, full;
    logic [IdxW-1:0]      hit_idx;
    logic [LINE_BITS-1:0] hit_data, head_data;
    logic [TAG_BITS-1:0]  req_tag, head_tag;
    logic [CntW-1:0]      count;
    logic                 unused_offset;

    assign req_tag       = mem_address_i[31:OFFSET_BITS];
    assign unused_offset = ^mem_address_i[OFFSET_BITS-1:0];
    assign full          = (count == CntW'(Depth));

    l2_wbuf_store #(
        .Depth (Depth)
    ) u_store (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .push_tag_i   (req_tag),
        .push_data_i  (mem_wdata_i),
        .pop_i        (pop),
        .ovr_i        (ovr),
        .ovr_idx_i    (hit_idx),
        .ovr_data_i   (mem_wdata_i),
        .lookup_tag_i (req_tag),
        .hit_o        (hit),
        .hit_idx_o    (hit_idx),
        .hit_data_o   (hit_data),
        .head_tag_o   (head_tag),
        .head_data_o  (head_data),
        .count_o      (count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rdata_d        = rdata_q;
        push           = 1'b0;
        pop            = 1'b0;
        ovr            = 1'b0;
        mem_resp_o     = 1'b0;
        mem_rdata_o    = '0;
        pmem_read_o    = 1'b0;
        pmem_write_o   = 1'b0;
        pmem_address_o = '0;
        pmem_wdata_o   = '0;

        case (state_q)
            StIdle: begin
                // Reads win over starting a drain; a drain is never entered while a
                // read waits.
                if (mem_read_i) begin
                    if (hit) begin
                        rdata_d = hit_data;
                        state_d = StRdAck;
                    end else begin
                        state_d = StReadMem;
                    end
                end else if (mem_write_i) begin
`ifdef L2_WBUF_COALESCE_EN
                    if (hit) begin
                        ovr     = 1'b1;
                        state_d = StWrAck;
                    end else if (full) begin
                        state_d = StDrain;
                    end else begin
                        push    = 1'b1;
                        state_d = StWrAck;
                    end
`else
                    // A matching line must leave first so each tag appears once.
                    if (hit || full) begin
                        state_d = StDrain;
                    end else begin
                        push    = 1'b1;
                        state_d = StWrAck;
                    end
`endif
                end else if (count != '0) begin
                    state_d = StDrain;
                end
            end
            StWrAck: begin
                mem_resp_o = 1'b1;
                state_d    = StIdle;
            end
            StRdAck: begin
                mem_resp_o  = 1'b1;
                mem_rdata_o = rdata_q;
                state_d     = StIdle;
            end
            StReadMem: begin
                pmem_read_o    = 1'b1;
                pmem_address_o = line_addr(req_tag);
                mem_resp_o     = pmem_resp_i;
                mem_rdata_o    = pmem_rdata_i;
                if (pmem_resp_i) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                pmem_write_o   = 1'b1;
                pmem_address_o = line_addr(head_tag);
                pmem_wdata_o   = head_data;
                if (pmem_resp_i) begin
                    pop     = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are forced quiet during reset, whatever the state register holds.
        if (!rst_ni) begin
            mem_resp_o     = 1'b0;
            mem_rdata_o    = '0;
            pmem_read_o    = 1'b0;
            pmem_write_o   = 1'b0;
            pmem_address_o = '0;
            pmem_wdata_o   = '0;
        end
    end

endmodule

// File: tb/tb_l2_write_buffer.sv
// tb_l2_write_buffer: scoreboard bench for l2_write_buffer. Expected memory writes and
// read data are queued when requests are issued and checked as the DUT produces them.
module tb_l2_write_buffer;

    localparam int Timeout = 200;
    localparam int MemLat  = 2;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] data;
    } wr_exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic         mem_resp;
    logic [255:0] mem_rdata;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int n_pmem_rd = 0;
    int n_pmem_rd_cyc = 0;
    int n_pmem_wr = 0;
    bit mem_stall = 1'b0;

    wr_exp_t      exp_wr_q[$];
    logic [255:0] exp_rd_q[$];

    always #5 clk = ~clk;

    l2_write_buffer #(
        .Depth (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .mem_read_i     (mem_read),
        .mem_write_i    (mem_write),
        .mem_address_i  (mem_address),
        .mem_wdata_i    (mem_wdata),
        .mem_resp_o     (mem_resp),
        .mem_rdata_o    (mem_rdata),
        .pmem_read_o    (pmem_read),
        .pmem_write_o   (pmem_write),
        .pmem_address_o (pmem_address),
        .pmem_wdata_o   (pmem_wdata),
        .pmem_resp_i    (pmem_resp),
        .pmem_rdata_i   (pmem_rdata)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mem_pattern(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_C3C3}};
    endfunction

    function automatic logic [255:0] line(input logic [31:0] seed);
        return {8{seed}};
    endfunction

    // Memory model: answers each request MemLat+1 cycles after it appears.
    initial begin
        int lat_cnt = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if ((pmem_read || pmem_write) && !mem_stall) begin
                if (lat_cnt == MemLat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = mem_pattern(pmem_address);
                    lat_cnt    = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pmem_read) n_pmem_rd_cyc++;
            if (pmem_write && pmem_resp) begin
                n_pmem_wr++;
                if (exp_wr_q.size() == 0) begin
                    check_eq("unexpected_drain", 256'(pmem_write), 256'(0));
                end else begin
                    wr_exp_t e;
                    e = exp_wr_q.pop_front();
                    check_eq("drain_addr", 256'(pmem_address), 256'(e.addr));
                    check_eq("drain_data", pmem_wdata, e.data);
                end
            end
            if (pmem_read && pmem_resp) begin
                n_pmem_rd++;
                check_eq("pmem_rd_addr", 256'(pmem_address), 256'({mem_address[31:5], 5'b0}));
            end
            if (mem_resp && mem_read) begin
                if (exp_rd_q.size() == 0) begin
                    check_eq("unexpected_rd_resp", 256'(mem_resp), 256'(0));
                end else begin
                    check_eq("rd_data", mem_rdata, exp_rd_q.pop_front());
                end
            end
        end
    end

    task automatic wait_resp(input string tag, output int lat);
        int n = 0;
        forever begin
            @(negedge clk);
            if (mem_resp || n >= Timeout) break;
            n++;
        end
        if (!mem_resp) check_eq(tag, 256'(mem_resp), 256'(1));
        lat = n;
        @(posedge clk);
        #1;
    endtask

    task automatic l2_write(input logic [31:0] a, input logic [255:0] d, output int lat);
        mem_write   = 1'b1;
        mem_address = a;
        mem_wdata   = d;
        wait_resp("wr_timeout", lat);
        mem_write = 1'b0;
    endtask

    task automatic l2_read(input logic [31:0] a, input logic [255:0] exp, output int lat);
        exp_rd_q.push_back(exp);
        mem_read    = 1'b1;
        mem_address = a;
        wait_resp("rd_timeout", lat);
        mem_read = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [255:0] d);
        wr_exp_t e;
        e.addr = a;
        e.data = d;
        exp_wr_q.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_wr_q.size() != 0 && n < Timeout) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_eq(tag, 256'(exp_wr_q.size()), 256'(0));
        check_eq({tag, "_count"}, 256'(dut.count), 256'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int base_wr, base_rd, base_rd_cyc;
        rst_n       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;

        // Reset: outputs quiet during and just after reset.
        repeat (2) @(negedge clk);
        check_eq("rst_outs", 256'({mem_resp, pmem_read, pmem_write}), 256'(0));
        check_eq("rst_paddr", 256'(pmem_address), 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_outs", 256'({mem_resp, pmem_read, pmem_write}), 256'(0));
        check_eq("post_rst_count", 256'(dut.count), 256'(0));
        @(posedge clk);
        #1;

        // 1: single eviction, 1-cycle ack, then drained.
        push_wr(32'h0000_1000, line(32'hD1D1_0001));
        l2_write(32'h0000_1000, line(32'hD1D1_0001), lat);
        check_eq("t1_wr_lat", 256'(lat), 256'(1));
        wait_drain("t1_drain");

        // 2: read hit served from the buffer, no memory read.
        base_rd_cyc = n_pmem_rd_cyc;
        push_wr(32'h0000_1000, line(32'hD2D2_0002));
        l2_write(32'h0000_1000, line(32'hD2D2_0002), lat);
        l2_read(32'h0000_1010, line(32'hD2D2_0002), lat);
        check_eq("t2_rd_lat", 256'(lat), 256'(1));
        check_eq("t2_no_pmem_rd", 256'(n_pmem_rd_cyc), 256'(base_rd_cyc));
        wait_drain("t2_drain");

        // 3: fill, then a fifth write forces exactly one drain before its ack.
        for (int i = 1; i <= 5; i++) begin
            push_wr(32'(i) << 12, line(32'hC300_0000 + 32'(i)));
        end
        for (int i = 1; i <= 4; i++) begin
            l2_write(32'(i) << 12, line(32'hC300_0000 + 32'(i)), lat);
            check_eq("t3_fill_lat", 256'(lat), 256'(1));
        end
        check_eq("t3_full_count", 256'(dut.count), 256'(4));
        base_wr = n_pmem_wr;
        l2_write(32'h0000_5000, line(32'hC300_0005), lat);
        check_eq("t3_forced_drains", 256'(n_pmem_wr), 256'(base_wr + 1));
        check_eq("t3_slow_ack", 256'(lat > MemLat + 1), 256'(1));
        wait_drain("t3_drain");

        // 4: read miss goes to memory ahead of pending drain.
        push_wr(32'h0000_1000, line(32'hD4D4_0004));
        l2_write(32'h0000_1000, line(32'hD4D4_0004), lat);
        base_wr = n_pmem_wr;
        base_rd = n_pmem_rd;
        l2_read(32'h0000_8004, mem_pattern(32'h0000_8000), lat);
        check_eq("t4_pmem_rd", 256'(n_pmem_rd), 256'(base_rd + 1));
        check_eq("t4_no_drain_first", 256'(n_pmem_wr), 256'(base_wr));
        wait_drain("t4_drain");

        // 5: repeated write to the same line.
        base_wr = n_pmem_wr;
`ifdef L2_WBUF_COALESCE_EN
        push_wr(32'h0000_1000, line(32'hD5D5_0002));
`else
        push_wr(32'h0000_1000, line(32'hD5D5_0001));
        push_wr(32'h0000_1000, line(32'hD5D5_0002));
`endif
        l2_write(32'h0000_1000, line(32'hD5D5_0001), lat);
        l2_write(32'h0000_1000, line(32'hD5D5_0002), lat);
        wait_drain("t5_drain");
`ifdef L2_WBUF_COALESCE_EN
        check_eq("t5_drains", 256'(n_pmem_wr - base_wr), 256'(1));
`else
        check_eq("t5_drains", 256'(n_pmem_wr - base_wr), 256'(2));
`endif

        // 6: reset mid-drain discards the line; later read goes to memory.
        mem_stall = 1'b1;
        l2_write(32'h0000_1000, line(32'hD6D6_0006), lat);
        begin
            int n = 0;
            while (!pmem_write && n < Timeout) begin
                @(negedge clk);
                n++;
            end
            check_eq("t6_drain_started", 256'(pmem_write), 256'(1));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t6_in_rst_pwr", 256'(pmem_write), 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t6_post_rst_pwr", 256'(pmem_write), 256'(0));
        check_eq("t6_post_rst_count", 256'(dut.count), 256'(0));
        mem_stall = 1'b0;
        @(posedge clk);
        #1;
        base_rd = n_pmem_rd;
        l2_read(32'h0000_1000, mem_pattern(32'h0000_1000), lat);
        check_eq("t6_rd_from_pmem", 256'(n_pmem_rd), 256'(base_rd + 1));
        repeat (4) @(negedge clk);
        check_eq("t6_no_drain", 256'(pmem_write), 256'(0));
        check_eq("rd_q_empty", 256'(exp_rd_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l2_write_buffer.md
Name: l2_write_buffer

Overview:
Write-back buffer between the L2 cache's physical-memory port and main memory.
- Absorbs dirty-line evictions with 1-cycle acknowledge.
- Serves L2 read misses that hit buffered lines.
- Drains buffered lines to memory whenever the L2 is idle.
- Upstream side presents the same line interface memory presents to L2, so it drops in with no L2 changes.

Parameters:
DEPTH, 4, number of 256-bit line entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
mem_read  in  1  L2 line read request, held until mem_resp
mem_write  in  1  L2 line write (eviction) request, held until mem_resp
mem_address  in  32  L2 line address; bits [4:0] ignored
mem_wdata  in  256  eviction data
mem_resp  out  1  one-cycle completion pulse to L2
mem_rdata  out  256  read data, valid with mem_resp
pmem_read  out  1  memory read request
pmem_write  out  1  memory write request
pmem_address  out  32  line-aligned memory address, bits [4:0]=0
pmem_wdata  out  256  memory write data
pmem_resp  in  1  memory completion
pmem_rdata  in  256  memory read data

Behaviour:
Clocking and reset:
- One clock, clk.
- Reset is synchronous and active-low on rst_n.
- Reset clears all entry valid bits, head, tail and count to 0 and sets state to IDLE.
- All outputs are 0 while in reset and in the cycle after it.
- Reset mid-DRAIN or mid-READ_MEM drops the pmem request next cycle; buffered dirty data is discarded.

Storage and matching:
- Circular FIFO of {valid, tag = addr[31:5], data[255:0]}; count width $clog2(DEPTH)+1.
- Matching compares addr[31:5] against all valid entries.

Requests:
- Sampled only in IDLE.
- mem_read and mem_write are never both high; behaviour is undefined if they are.
- After a mem_resp pulse, upstream deasserts the request or presents a new one next cycle.

States: IDLE, WR_ACK, RD_ACK, READ_MEM, DRAIN. From IDLE:
- mem_write with count<DEPTH and no match: push at tail, go WR_ACK. mem_resp=1 for that cycle, then IDLE. Latency is 1 cycle.
- mem_write that matches the head while the head is draining: stall in IDLE until the drain completes.
- mem_write with count==DEPTH: go DRAIN (forced). The write is accepted in IDLE after pmem_resp.
- mem_read that matches an entry: capture the entry data, go RD_ACK. mem_resp=1 with mem_rdata=entry data, then IDLE. No pmem access.
- mem_read with no match: go READ_MEM.
  - pmem_read=1, pmem_address={addr[31:5],5'b0}.
  - mem_rdata=pmem_rdata and mem_resp=pmem_resp combinationally.
  - Return to IDLE on pmem_resp.
  - Reads take priority over starting a drain.
- No request and count>0: go DRAIN.
  - pmem_write=1, pmem_address={head.tag,5'b0}, pmem_wdata=head.data, held stable.
  - On pmem_resp: pop head, count-1, go IDLE.
  - A drain, once started, is never aborted by upstream requests; they wait.

Boundary rules:
- Request arriving in the same cycle as pmem_resp in DRAIN: handled from IDLE next cycle.
- count never exceeds DEPTH and never underflows.
- Head and tail pointers wrap modulo DEPTH.

Optional Feature:
Macro: L2_WBUF_COALESCE_EN
- Defined: a mem_write matching a valid entry that is not the draining head overwrites that entry's data in place. It acks via WR_ACK and count is unchanged.
- Undefined: a mem_write matching any valid entry stalls in IDLE, draining as needed, until that entry has been popped. It then pushes a new entry.
- Either way, at most one valid entry per tag, so read hits are unambiguous.

Decomposition:
- Package l2_wbuf_pkg holds:
  - state enum wbuf_state_t
  - entry struct wbuf_entry_t
  - LINE_BITS=256, OFFSET_BITS=5, TAG_BITS=27
- Sub-module l2_wbuf_store: entry array, head/tail/count, parallel tag match (hit, hit_idx), push/pop/overwrite ports.
- Top level holds the FSM and output muxing.

Test Plan:
1. Reset, write 0x0000_1000 D1, then idle -> mem_resp 1 cycle later. Next IDLE cycle enters DRAIN: pmem_write=1, pmem_address=0x0000_1000, pmem_wdata=D1. count returns to 0 after pmem_resp.
2. Write 0x1000 D1, then read 0x1000 immediately -> mem_resp after 1 cycle, mem_rdata=D1, pmem_read never asserted.
3. Write 0x1000, 0x2000, 0x3000, 0x4000 (full), then write 0x5000 -> DRAIN of 0x1000 first. The 0x5000 mem_resp arrives only after pmem_resp plus 1 cycle.
4. Buffer holds 0x1000, then read 0x8000 -> pmem_read with address 0x8000 before any drain. mem_rdata equals pmem_rdata in the pmem_resp cycle.
5. Write 0x1000 D1, write 0x1000 D2, then idle -> with macro: one pmem_write, data D2. Without macro: two pmem_writes, D1 then D2.
6. rst_n=0 during DRAIN -> pmem_write=0 next cycle, count=0. A subsequent read of the drained address goes to pmem.
